spi_adc_responder: RTL and testbench
====================================

// Module: spi_adc_responder
// PURPOSE
//  SPI responder (slave) for the robot's ADC read path: the far end of the spi master
//  (clk, sclk, cs, din, dout, count). Emulates a 12-bit, 8-channel ADC frame.
//  Each 16-bit frame samples the master's command bits to select the next channel and
//  returns the current channel's 12-bit sample MSB-first. Used as a synthesizable sensor
//  model in benches and on-FPGA loopback; all SPI inputs are oversampled on clk.
// PARAMETERS
//  DATA_W      12  sample width returned per frame
//  FRAME_W     16  SCLK rising edges per frame
//  NUM_CH      8   channels in ch_data
//  ADDR_W      3   channel address width
//  ADDR_MSB    13  rx_word bit index of address MSB (address = rx_word[13:11])
//  SYNC_STAGES 2   synchronizer flops on sclk/cs/din (>=2)
// PORTS
//  clk          in   1               system clock; must be >= 8x SCLK frequency
//  rst_n        in   1               asynchronous active-low reset
//  ch_data      in   NUM_CH*DATA_W   channel samples; ch0 in [DATA_W-1:0]
//  spi_sclk     in   1               master SCLK; idles high or low
//  spi_cs       in   1               chip select, active low
//  spi_din      in   1               command bits from master dout
//  spi_dout     out  1               data to master din
//  spi_dout_oe  out  1               1 while selected (for top-level tristate)
//  cur_addr     out  ADDR_W          channel returned in the current/next frame
//  rx_word      out  FRAME_W         last complete command word received
//  frame_done   out  1               1-clk pulse: full frame completed
//  frame_abort  out  1               1-clk pulse: cs released mid-frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, bit_cnt=0, shift registers 0.
//  Input path: SYNC_STAGES flops per input plus one history flop; edges are detected
//   from the last two stages. Response latency to an SCLK/CS edge: SYNC_STAGES+1 clk.
//  FSM:
//   IDLE   cs_s=1. spi_dout=0, spi_dout_oe=0. On cs fall go to ACTIVE:
//          tx_sr <= {(FRAME_W-DATA_W)'b0, ch_data[cur_addr]} (snapshot), bit_cnt <= 0.
//   ACTIVE spi_dout_oe=1, spi_dout=tx_sr[FRAME_W-1].
//          SCLK rise: rx_sr <= {rx_sr[FRAME_W-2:0], din_s}; bit_cnt++.
//          SCLK fall with bit_cnt>0: tx_sr <= tx_sr<<1 (zero fill).
//          Falls before the first rise are ignored, which covers both SCLK idle levels.
//          When bit_cnt reaches FRAME_W: rx_word <= rx_sr (incl. the final bit),
//          cur_addr <= rx_sr[ADDR_MSB -: ADDR_W], frame_done=1 for one clk, go to DONE.
//          cs rise (bit_cnt<FRAME_W): frame_abort=1 for one clk, go to IDLE.
//          cur_addr and rx_word are unchanged on abort.
//   DONE   spi_dout=0, spi_dout_oe=1. Further SCLK edges are ignored.
//          On cs rise go to IDLE with no pulse.
//  Simultaneous edges (same clk): cs rise has priority over SCLK edges.
//  A cs fall in the same clk as an SCLK edge starts the frame. That SCLK edge is ignored.
//  The new address applies to the NEXT frame, per standard ADC pipelining.
//  Frame 1 after reset returns ch0.
//  ch_data changes during a frame have no effect until the next cs fall.
//  bit_cnt is $clog2(FRAME_W+1) bits wide and never wraps. Runs of more than FRAME_W clocks stay in DONE.
//  rst_n low mid-frame: immediate return to reset values.
//  After release, the FSM waits for a fresh cs fall. A cs already low does not start a frame.
// TESTING
//  T1 reset: rst_n=0 with cs low and SCLK toggling -> all outputs 0. After release,
//     no frame starts until cs goes high then low.
//  T2 single read: ch0=12'hA5C, 16 SCLK cycles, din=16'h0000 -> master captures 16'h0A5C.
//     frame_done pulses once; cur_addr=0.
//  T3 address pipelining: ch3=12'h123, ch5=12'hFFF.
//     Frame A din=16'h1800 returns ch0, cur_addr=3.
//     Frame B din=16'h2800 returns 16'h0123, cur_addr=5.
//     Frame C returns 16'h0FFF.
//  T4 abort: cs high after 7 SCLK rises -> frame_abort pulses, no frame_done,
//     rx_word/cur_addr unchanged. The next full frame returns the same channel.
//  T5 over-clocked frame: 20 SCLK cycles -> frame_done exactly once.
//     dout=0 after bit 16; rx_word holds the first 16 bits.
//  T6 both SCLK idle levels (high, low), with clk/SCLK=8 and clk/SCLK=40 -> identical
//     returned words; spi_dout_oe tracks cs within SYNC_STAGES+1 clk.

Source files
------------

// File: rtl/spi_adc_responder_if.sv
// SPI pin bundle between an SPI master and the ADC responder.
// Latency: none; this is wiring only.
// Backpressure: none; the master owns all SPI timing.
interface spi_adc_responder_if;
  logic spi_sclk;
  logic spi_cs;
  logic spi_din;
  logic spi_dout;
  logic spi_dout_oe;

  modport master (
    output spi_sclk,
    output spi_cs,
    output spi_din,
    input  spi_dout,
    input  spi_dout_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs,
    input  spi_din,
    output spi_dout,
    output spi_dout_oe
  );
endinterface

// File: rtl/spi_adc_responder.sv
// SPI ADC responder: returns the 12-bit sample of the selected channel per 16-bit frame.
// Latency: SYNC_STAGES+1 clk from any SCLK/CS pin edge to the registered reaction.
// Backpressure: none; fully paced by the master's SCLK/CS, inputs oversampled on clk.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int FRAME_W     = 16,
  parameter int NUM_CH      = 8,
  parameter int ADDR_W      = 3,
  parameter int ADDR_MSB    = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  spi_adc_responder_if.slave       spi,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic [FRAME_W-1:0]       rx_word,
  output logic                     frame_done,
  output logic                     frame_abort
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] rx_sr;
  logic               dout_q;
  logic               oe_q;

  // Index SYNC_STAGES-1 is the last synchronizer stage, index SYNC_STAGES the history flop.
  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES:0]   cs_q;
  logic [SYNC_STAGES-1:0] din_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
  logic [FRAME_W-1:0] rx_next;
  logic [FRAME_W-1:0] tx_snap;
  logic [DATA_W-1:0]  ch_arr [NUM_CH];

  // Oversample the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '0;
      din_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi.spi_sclk};
      cs_q   <= {cs_q[SYNC_STAGES-1:0], spi.spi_cs};
      din_q  <= {din_q[SYNC_STAGES-2:0], spi.spi_din};
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign din_s     = din_q[SYNC_STAGES-1];

  // Unpack the flat channel bus so the current address can select a sample.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  // rx_next includes the bit arriving with the current SCLK rise, so the
  // completing rise can publish the whole word in the same clk.
  assign rx_next = {rx_sr[FRAME_W-2:0], din_s};
  assign tx_snap = {{(FRAME_W-DATA_W){1'b0}}, ch_arr[cur_addr]};

  assign spi.spi_dout    = dout_q;
  assign spi.spi_dout_oe = oe_q;

  // Frame FSM: cs edges take priority over SCLK edges; dout/oe are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      cur_addr    <= '0;
      rx_word     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          dout_q <= 1'b0;
          oe_q   <= 1'b0;
          // Any SCLK edge coinciding with the cs fall is deliberately dropped.
          if (cs_fall) begin
            state   <= ACTIVE;
            tx_sr   <= tx_snap;
            bit_cnt <= '0;
            dout_q  <= tx_snap[FRAME_W-1];
            oe_q    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            state       <= IDLE;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_LAST) begin
              rx_word    <= rx_next;
              cur_addr   <= rx_next[ADDR_MSB -: ADDR_W];
              frame_done <= 1'b1;
              dout_q     <= 1'b0;
              state      <= DONE;
            end
          end else if (sclk_fall && (bit_cnt != '0)) begin
            // A fall before the first rise is the idle-high lead-in and is skipped.
            tx_sr  <= tx_sr << 1;
            dout_q <= tx_sr[FRAME_W-2];
          end
        end
        DONE: begin
          dout_q <= 1'b0;
          if (cs_rise) begin
            state <= IDLE;
            oe_q  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          dout_q <= 1'b0;
          oe_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for the SPI ADC responder acting as the SPI master.
// Latency: frames paced by bench-chosen SCLK half periods in clk cycles.
// Backpressure: none; the bench drives all SPI timing.
module tb_spi_adc_responder;

  localparam logic [95:0] CH_INIT = {12'h777, 12'h666, 12'hFFF, 12'h444,
                                     12'h123, 12'h222, 12'h111, 12'hA5C};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] ch_data;
  logic [2:0]  cur_addr;
  logic [15:0] rx_word;
  logic        frame_done;
  logic        frame_abort;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  spi_adc_responder_if bus ();

  spi_adc_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_data     (ch_data),
    .spi         (bus),
    .cur_addr    (cur_addr),
    .rx_word     (rx_word),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  // Count single-clk status pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1)  done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One master transaction; bits past 16 drive din=1. Returns dout sampled before each rise.
  task automatic frame(input logic [15:0] cmd, input int nbits, input int half,
                       input bit idle_hi, input bit poke, output logic [31:0] cap);
    cap = '0;
    bus.spi_cs = 1'b0;
    tick(2);
    chk("oe_before_sync", {31'b0, bus.spi_dout_oe}, 32'd0);
    tick(1);
    chk("oe_selected", {31'b0, bus.spi_dout_oe}, 32'd1);
    tick(half - 3);
    for (int i = 0; i < nbits; i++) begin
      if (idle_hi) bus.spi_sclk = 1'b0;
      bus.spi_din = (i < 16) ? cmd[15-i] : 1'b1;
      if (poke && i == 8) ch_data = ~ch_data;
      tick(half);
      cap = {cap[30:0], bus.spi_dout};
      bus.spi_sclk = 1'b1;
      tick(half);
      if (!idle_hi) bus.spi_sclk = 1'b0;
    end
    tick(half);
    bus.spi_cs = 1'b1;
    tick(2);
    chk("oe_hold_after_cs", {31'b0, bus.spi_dout_oe}, 32'd1);
    tick(1);
    chk("oe_released", {31'b0, bus.spi_dout_oe}, 32'd0);
    tick(half);
  endtask

  initial begin
    logic [31:0] cap;
    int d0;
    int a0;

    // T1: reset with cs low and SCLK toggling
    rst_n = 1'b0;
    ch_data = CH_INIT;
    bus.spi_cs = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_din = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      bus.spi_sclk = ~bus.spi_sclk;
      tick(2);
    end
    chk("rst_dout", {31'b0, bus.spi_dout}, 32'd0);
    chk("rst_oe", {31'b0, bus.spi_dout_oe}, 32'd0);
    chk("rst_cur_addr", {29'b0, cur_addr}, 32'd0);
    chk("rst_rx_word", {16'b0, rx_word}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    chk("rst_abort", {31'b0, frame_abort}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.spi_sclk = ~bus.spi_sclk;
      tick(4);
    end
    chk("no_frame_cs_low_oe", {31'b0, bus.spi_dout_oe}, 32'd0);
    chk("no_frame_cs_low_done", done_cnt, 32'd0);
    chk("no_frame_cs_low_rx", {16'b0, rx_word}, 32'd0);
    bus.spi_cs = 1'b1;
    bus.spi_sclk = 1'b0;
    tick(8);

    // T2: single read of ch0
    d0 = done_cnt;
    frame(16'h0000, 16, 4, 1'b0, 1'b0, cap);
    chk("t2_data", {16'b0, cap[15:0]}, 32'h0A5C);
    chk("t2_done_once", done_cnt - d0, 32'd1);
    chk("t2_cur_addr", {29'b0, cur_addr}, 32'd0);

    // T3: address pipelining
    frame(16'h1800, 16, 4, 1'b0, 1'b0, cap);
    chk("t3a_data", {16'b0, cap[15:0]}, 32'h0A5C);
    chk("t3a_cur_addr", {29'b0, cur_addr}, 32'd3);
    chk("t3a_rx_word", {16'b0, rx_word}, 32'h1800);
    frame(16'h2800, 16, 4, 1'b0, 1'b0, cap);
    chk("t3b_data", {16'b0, cap[15:0]}, 32'h0123);
    chk("t3b_cur_addr", {29'b0, cur_addr}, 32'd5);
    frame(16'h1800, 16, 4, 1'b0, 1'b0, cap);
    chk("t3c_data", {16'b0, cap[15:0]}, 32'h0FFF);
    chk("t3c_cur_addr", {29'b0, cur_addr}, 32'd3);

    // T4: abort after 7 rises leaves address and word untouched
    d0 = done_cnt;
    a0 = abort_cnt;
    frame(16'h2800, 7, 4, 1'b0, 1'b0, cap);
    chk("t4_abort_once", abort_cnt - a0, 32'd1);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_rx_word_kept", {16'b0, rx_word}, 32'h1800);
    chk("t4_cur_addr_kept", {29'b0, cur_addr}, 32'd3);
    frame(16'h0000, 16, 4, 1'b0, 1'b0, cap);
    chk("t4_next_data", {16'b0, cap[15:0]}, 32'h0123);
    chk("t4_next_cur_addr", {29'b0, cur_addr}, 32'd0);

    // T5: 20 SCLK cycles, extra bits must not shift in or out
    d0 = done_cnt;
    frame(16'h2800, 20, 4, 1'b0, 1'b0, cap);
    chk("t5_data_20b", {12'b0, cap[19:0]}, 32'h000A5C0);
    chk("t5_done_once", done_cnt - d0, 32'd1);
    chk("t5_rx_word", {16'b0, rx_word}, 32'h2800);
    chk("t5_cur_addr", {29'b0, cur_addr}, 32'd5);

    // T6: both SCLK idle levels at two clk/SCLK ratios, ch5 returned each time
    frame(16'h2800, 16, 4, 1'b0, 1'b0, cap);
    chk("t6_lo_r8", {16'b0, cap[15:0]}, 32'h0FFF);
    bus.spi_sclk = 1'b1;
    tick(8);
    frame(16'h2800, 16, 4, 1'b1, 1'b0, cap);
    chk("t6_hi_r8", {16'b0, cap[15:0]}, 32'h0FFF);
    bus.spi_sclk = 1'b0;
    tick(8);
    frame(16'h2800, 16, 20, 1'b0, 1'b0, cap);
    chk("t6_lo_r40", {16'b0, cap[15:0]}, 32'h0FFF);
    bus.spi_sclk = 1'b1;
    tick(8);
    // ch_data flips mid-frame; the snapshot taken at cs fall must be returned
    frame(16'h2800, 16, 20, 1'b1, 1'b1, cap);
    chk("t6_hi_r40_snapshot", {16'b0, cap[15:0]}, 32'h0FFF);
    ch_data = CH_INIT;
    chk("t6_final_cur_addr", {29'b0, cur_addr}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
